// File: rtl/alert_diff_receiver.sv
// Receiver side of the differential alert handshake: decodes alert_p/alert_n,
// acknowledges alerts, issues level-toggle pings and flags integrity/timeouts.
module alert_diff_receiver #(
  parameter bit          AsyncOn     = 1'b1,
  parameter int unsigned PingTimeout = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic alert_p_i,
  input  logic alert_n_i,
  output logic ack_p_o,
  output logic ack_n_o,
  output logic ping_p_o,
  output logic ping_n_o,
  input  logic ping_req_i,
  output logic alert_o,
  output logic ping_ok_o,
  output logic ping_timeout_o,
  output logic integ_fail_o
);

  localparam int unsigned CntW = $clog2(PingTimeout + 1);

  typedef enum logic [1:0] {
    Idle,
    AckHigh,
    Pause0,
    Pause1
  } state_e;

  // Received pair as {p, n}; reset value is the L level.
  logic [1:0] pair;

  if (AsyncOn) begin : g_sync
    logic [1:0] sync1_q, sync2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync1_q <= 2'b01;
        sync2_q <= 2'b01;
      end else begin
        sync1_q <= {alert_p_i, alert_n_i};
        sync2_q <= sync1_q;
      end
    end
    assign pair = sync2_q;
  end else begin : g_nosync
    assign pair = {alert_p_i, alert_n_i};
  end

  logic lvl_h, lvl_l, integ_fail;
  assign lvl_h      = (pair == 2'b10);
  assign lvl_l      = (pair == 2'b01);
  assign integ_fail = (pair[1] == pair[0]);

  state_e          state_q, state_d;
  logic            ack_q, ack_d;
  logic            ping_q, ping_d;
  logic            pending_q, pending_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            alert_q, alert_d;
  logic            ping_ok_q, ping_ok_d;
  logic            timeout_q, timeout_d;
  logic            integ_q;
  logic            answer;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    ping_d    = ping_q;
    alert_d   = 1'b0;
    ping_ok_d = 1'b0;
    timeout_d = 1'b0;
    answer    = 1'b0;

    if (integ_fail) begin
      state_d = Idle;
    end else begin
      unique case (state_q)
        Idle: begin
          if (lvl_h) begin
            state_d = AckHigh;
            answer  = 1'b1;
          end
        end
        AckHigh: if (lvl_l) state_d = Pause0;
        Pause0:  state_d = Pause1;
        Pause1:  state_d = Idle;
        default: state_d = Idle;
      endcase
    end

    // Attribution uses the pending flag as it stood before this cycle.
    if (answer) begin
      if (pending_q) begin
        ping_ok_d = 1'b1;
        pending_d = 1'b0;
      end else begin
        alert_d = 1'b1;
      end
    end else if (pending_q) begin
      if (cnt_q == CntW'(PingTimeout - 1)) begin
        timeout_d = 1'b1;
        pending_d = 1'b0;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    if (ping_req_i && !pending_q) begin
      ping_d    = ~ping_q;
      pending_d = 1'b1;
      cnt_d     = '0;
    end

    ack_d = (state_d == AckHigh);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= Idle;
      ack_q     <= 1'b0;
      ping_q    <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      alert_q   <= 1'b0;
      ping_ok_q <= 1'b0;
      timeout_q <= 1'b0;
      integ_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      ping_q    <= ping_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      alert_q   <= alert_d;
      ping_ok_q <= ping_ok_d;
      timeout_q <= timeout_d;
      integ_q   <= integ_fail;
    end
  end

  assign ack_p_o        = ack_q;
  assign ack_n_o        = ~ack_q;
  assign ping_p_o       = ping_q;
  assign ping_n_o       = ~ping_q;
  assign alert_o        = alert_q;
  assign ping_ok_o      = ping_ok_q;
  assign ping_timeout_o = timeout_q;
  assign integ_fail_o   = integ_q;

endmodule

// File: tb/tb_alert_diff_receiver.sv
// Scoreboard bench for alert_diff_receiver: two instances (direct sampling with
// PingTimeout=8, synchronized with PingTimeout=16) checked against a cycle model.
module tb_alert_diff_receiver;

  typedef struct packed {
    logic ack_p;
    logic ack_n;
    logic ping_p;
    logic ping_n;
    logic alert;
    logic ping_ok;
    logic ping_to;
    logic integ;
  } obs_t;

  localparam obs_t RstObs = obs_t'(8'b0101_0000);

  logic clk = 1'b0;
  logic rst_ni;
  logic alert_p, alert_n, ping_req;
  logic [1:0] ack_p, ack_n, ping_p, ping_n, alrt, pok, pto, integ;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alert_diff_receiver #(.AsyncOn(1'b0), .PingTimeout(8)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_ni), .alert_p_i(alert_p), .alert_n_i(alert_n),
    .ack_p_o(ack_p[0]), .ack_n_o(ack_n[0]), .ping_p_o(ping_p[0]), .ping_n_o(ping_n[0]),
    .ping_req_i(ping_req), .alert_o(alrt[0]), .ping_ok_o(pok[0]),
    .ping_timeout_o(pto[0]), .integ_fail_o(integ[0])
  );

  alert_diff_receiver #(.AsyncOn(1'b1), .PingTimeout(16)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .alert_p_i(alert_p), .alert_n_i(alert_n),
    .ack_p_o(ack_p[1]), .ack_n_o(ack_n[1]), .ping_p_o(ping_p[1]), .ping_n_o(ping_n[1]),
    .ping_req_i(ping_req), .alert_o(alrt[1]), .ping_ok_o(pok[1]),
    .ping_timeout_o(pto[1]), .integ_fail_o(integ[1])
  );

  // Reference model: input delay line, "acknowledging" flag plus a cooldown,
  // and a ping that ages until answered or expired.
  int         m_pt    [2] = '{8, 16};
  bit         m_async [2] = '{1'b0, 1'b1};
  logic [1:0] m_h1 [2];
  logic [1:0] m_h2 [2];
  bit         m_acking [2];
  int         m_cool [2];
  bit         m_pend [2];
  int         m_age [2];
  bit         m_plvl [2];

  obs_t q0[$];
  obs_t q1[$];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_h1[k] = 2'b01; m_h2[k] = 2'b01;
      m_acking[k] = 1'b0; m_cool[k] = 0;
      m_pend[k] = 1'b0; m_age[k] = 0; m_plvl[k] = 1'b0;
    end
  endtask

  task automatic model_step(input int k, input logic [1:0] raw, input logic req, output obs_t e);
    logic [1:0] s;
    bit hi, lo, bad, ans, old;
    s = m_async[k] ? m_h2[k] : raw;
    m_h2[k] = m_h1[k];
    m_h1[k] = raw;
    hi  = (s == 2'b10);
    lo  = (s == 2'b01);
    bad = !(hi || lo);
    e   = '0;
    ans = 1'b0;
    if (bad) begin
      m_acking[k] = 1'b0; m_cool[k] = 0;
    end else if (m_acking[k]) begin
      if (lo) begin m_acking[k] = 1'b0; m_cool[k] = 2; end
    end else if (m_cool[k] > 0) begin
      m_cool[k]--;
    end else if (hi) begin
      m_acking[k] = 1'b1; ans = 1'b1;
    end
    old = m_pend[k];
    if (ans) begin
      if (old) e.ping_ok = 1'b1;
      else     e.alert   = 1'b1;
    end
    if (old) begin
      if (e.ping_ok) m_pend[k] = 1'b0;
      else if (m_age[k] == m_pt[k] - 1) begin e.ping_to = 1'b1; m_pend[k] = 1'b0; end
      else m_age[k]++;
    end
    if (req && !old) begin
      m_plvl[k] = ~m_plvl[k]; m_pend[k] = 1'b1; m_age[k] = 0;
    end
    e.ack_p  = m_acking[k];
    e.ack_n  = !m_acking[k];
    e.ping_p = m_plvl[k];
    e.ping_n = !m_plvl[k];
    e.integ  = bad;
  endtask

  function automatic obs_t dut_obs(input int k);
    return {ack_p[k], ack_n[k], ping_p[k], ping_n[k], alrt[k], pok[k], pto[k], integ[k]};
  endfunction

  task automatic check(input string name, input int k, input obs_t got, input obs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d @%0t: got ackp/ackn/pingp/pingn/alert/ok/to/integ=%b expected %b",
               name, k, $time, got, exp);
    end
  endtask

  task automatic push_step();
    obs_t e;
    model_step(0, {alert_p, alert_n}, ping_req, e); q0.push_back(e);
    model_step(1, {alert_p, alert_n}, ping_req, e); q1.push_back(e);
  endtask

  task automatic cyc(input logic ap, input logic an, input logic req);
    @(negedge clk);
    alert_p = ap; alert_n = an; ping_req = req;
    push_step();
  endtask

  task automatic hold(input logic ap, input logic an, input int n);
    repeat (n) cyc(ap, an, 1'b0);
  endtask

  task automatic check_rst(input string name);
    check(name, 0, dut_obs(0), RstObs);
    check(name, 1, dut_obs(1), RstObs);
  endtask

  task automatic check_drained();
    n_checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d/%0d entries pending expected 0/0", q0.size(), q1.size());
    end
  endtask

  // Monitor: each cycle out of reset, compare DUT outputs with the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_ni === 1'b1) begin
        if (q0.size() > 0) check("cycle", 0, dut_obs(0), q0.pop_front());
        if (q1.size() > 0) check("cycle", 1, dut_obs(1), q1.pop_front());
      end
    end
  end

  initial begin
    int r, len;
    logic ap, an;
    rst_ni = 1'b0; alert_p = 1'b0; alert_n = 1'b1; ping_req = 1'b0;
    model_reset();
    #3;
    check_rst("reset");
    @(negedge clk);
    rst_ni = 1'b1;
    push_step();
    hold(1'b0, 1'b1, 4);

    // plain alert handshake, then H right at the end of the pause window
    hold(1'b1, 1'b0, 4); hold(1'b0, 1'b1, 3); hold(1'b1, 1'b0, 2); hold(1'b0, 1'b1, 6);
    // ping answered five cycles later, then a second ping toggling back
    cyc(1'b0, 1'b1, 1'b1); hold(1'b0, 1'b1, 4); hold(1'b1, 1'b0, 3); hold(1'b0, 1'b1, 6);
    cyc(1'b0, 1'b1, 1'b1); hold(1'b0, 1'b1, 2); hold(1'b1, 1'b0, 3); hold(1'b0, 1'b1, 6);
    // unanswered ping expires, later H is a genuine alert
    cyc(1'b0, 1'b1, 1'b1); hold(1'b0, 1'b1, 20); hold(1'b1, 1'b0, 3); hold(1'b0, 1'b1, 6);
    // integrity failure during AckHigh
    hold(1'b1, 1'b0, 3); hold(1'b1, 1'b1, 3); hold(1'b0, 1'b1, 6);
    hold(1'b0, 1'b0, 2); hold(1'b0, 1'b1, 4);
    // ping request coincident with H detection, then a second handshake
    cyc(1'b1, 1'b0, 1'b1); hold(1'b1, 1'b0, 2); hold(1'b0, 1'b1, 4);
    hold(1'b1, 1'b0, 3); hold(1'b0, 1'b1, 20);

    // randomized traffic
    repeat (80) begin
      r   = int'($urandom_range(0, 19));
      len = int'($urandom_range(1, 6));
      if (r < 9)       begin ap = 1'b0; an = 1'b1; end
      else if (r < 18) begin ap = 1'b1; an = 1'b0; end
      else if (r == 18) begin ap = 1'b0; an = 1'b0; end
      else             begin ap = 1'b1; an = 1'b1; end
      for (int i = 0; i < len; i++) cyc(ap, an, $urandom_range(0, 11) == 0);
    end

    // reset while acknowledging with a ping outstanding
    hold(1'b0, 1'b1, 30); hold(1'b1, 1'b0, 4); cyc(1'b1, 1'b0, 1'b1); hold(1'b1, 1'b0, 1);
    @(posedge clk);
    #2;
    check_drained();
    rst_ni = 1'b0; alert_p = 1'b0; alert_n = 1'b1; ping_req = 1'b0;
    #1;
    check_rst("mid_reset");
    model_reset();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    push_step();
    hold(1'b0, 1'b1, 40); hold(1'b1, 1'b0, 3); hold(1'b0, 1'b1, 6);

    @(posedge clk);
    #2;
    check_drained();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alert_diff_receiver.md
Name: alert_diff_receiver

Overview:
- Synthesizable receiver side of the differential alert handshake.
- Consumes the sender's alert_p/alert_n pair and drives the ack_p/ack_n and ping_p/ping_n pairs back to it.
- Decodes alert events, answers ping requests, and flags differential-encoding integrity failures and ping timeouts.
- Sits in the alert handler, one instance per alert source; the DV alert agent drives/monitors its pins.

Parameters:
- AsyncOn, 1: 1 = 2-flop synchronizer on alert_p/alert_n (adds 2 cycles of latency); 0 = inputs sampled directly.
- PingTimeout, 64: cycles a ping may stay unanswered before ping_timeout_o fires; legal range 2..65535.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- alert_p_i  input  1  sender differential alert, positive rail
- alert_n_i  input  1  sender differential alert, negative rail
- ack_p_o  output  1  ack to sender, positive rail
- ack_n_o  output  1  ack to sender, negative rail
- ping_p_o  output  1  ping to sender, positive rail (level-toggle encoded)
- ping_n_o  output  1  ping to sender, negative rail
- ping_req_i  input  1  one-cycle request to issue a ping
- alert_o  output  1  one-cycle pulse: genuine alert received
- ping_ok_o  output  1  one-cycle pulse: ping answered
- ping_timeout_o  output  1  one-cycle pulse: ping not answered in time
- integ_fail_o  output  1  alert pair not complementary this cycle

Behaviour:
- Clock and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: ack_p_o=0, ack_n_o=1, ping_p_o=0, ping_n_o=1; all pulse outputs 0; FSM=Idle; ping_pending=0; counter=0; synchronizer flops reset to p=0, n=1.
- Decode, applied to the synchronized (or raw) pair (ap, an):
  - ap=1, an=0: level H.
  - ap=0, an=1: level L.
  - ap==an: integrity fail.
- Integrity fail:
  - integ_fail_o is registered: it asserts the cycle after the failing sample and stays high while the condition persists.
  - The FSM is forced to Idle, ack is driven low (ack_p=0, ack_n=1), and no alert_o/ping_ok_o is generated.
  - ping_pending and the timeout counter are unaffected.
- FSM states: Idle, AckHigh, Pause0, Pause1.
  - Idle, level H seen: next cycle ack_p=1/ack_n=0 and state AckHigh.
    - If ping_pending=1: pulse ping_ok_o and clear ping_pending.
    - Else: pulse alert_o.
    - The pulse is coincident with the first ack_p=1 cycle.
  - AckHigh: hold ack while level H. On level L: next cycle ack_p=0/ack_n=1 and state Pause0.
  - Pause0 -> Pause1 -> Idle, one cycle each, unconditionally. Level H during Pause0/Pause1 is ignored until Idle.
  - Latency with AsyncOn=0: alert_p_i rising sampled at edge t gives ack_p_o=1 and the alert_o pulse in the cycle after edge t. AsyncOn=1 adds 2 cycles.
- Ping issue:
  - ping_req_i=1 with ping_pending=0: toggle ping_p_o and ping_n_o (they stay complementary), set ping_pending, clear the counter.
  - ping_req_i while ping_pending=1: ignored. No toggle, no counter restart.
  - Ping issue is legal in any FSM state.
- Response attribution uses ping_pending as registered before the current cycle. A ping_req_i coincident with an Idle level-H detection yields alert_o, and the new ping stays pending.
- Timeout:
  - While ping_pending=1 the counter increments each cycle.
  - When the counter reaches PingTimeout-1 and no answer occurs that cycle: pulse ping_timeout_o, clear ping_pending, zero the counter.
  - An answer and a timeout in the same cycle: the answer wins (ping_ok_o=1, ping_timeout_o=0).
  - Counter width is $clog2(PingTimeout+1) and it never wraps.
- Reset asserted mid-handshake immediately restores all reset values, including ping rails (ping_p_o returns to 0 regardless of toggle history).

Test Plan:
- AsyncOn=0, drive alert pair to H for 4 cycles then L -> ack_p_o=1 the cycle after H is sampled. alert_o pulses exactly once with ack rise. ack drops the cycle after L is sampled. A new H accepted no earlier than 3 cycles after ack drop.
- ping_req_i pulse, sender answers with H 5 cycles later -> ping_p_o toggles 0->1 once. ping_ok_o pulses once, alert_o stays 0. Second ping toggles ping_p_o 1->0.
- PingTimeout=8, ping_req_i with no answer -> ping_timeout_o pulses 8 cycles after the ping toggle. A subsequent H produces alert_o, not ping_ok_o.
- Drive alert_p_i=alert_n_i=1 for 3 cycles during AckHigh -> integ_fail_o high for 3 cycles lagged by 1. Ack returns to 0 and FSM is Idle. No alert_o.
- ping_req_i same cycle as H sampled in Idle -> alert_o=1, ping_ok_o=0, ping_pending=1. A second handshake then yields ping_ok_o.
- AsyncOn=1: assert rst_ni low while ack_p_o=1 with a ping pending -> outputs immediately reset values. After release, ping_timeout_o never fires. Ack latency measures 3 cycles.
